// File: rtl/cmp_pipe.sv
// Pipelined magnitude comparator, one CHUNK-bit slice per stage, MSB slice first.
// Define CMP_COUNTERS_EN to add saturating eq/gt/lt result counters.
module cmp_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt
`ifdef CMP_COUNTERS_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt
`endif
);

    localparam int NSTG = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH % CHUNK != 0 || CNT_W < 1) begin : g_bad
        $error("cmp_pipe: WIDTH must be a nonzero multiple of CHUNK");
    end

    logic             adv;
    logic [NSTG-1:0]  vld, dec, gtr;
    logic [WIDTH-1:0] sgn_m, a_m, b_m;

    // Flipping the sign bits maps two's-complement order onto unsigned order
    assign sgn_m = WIDTH'(is_signed) << (WIDTH - 1);
    assign a_m   = a ^ sgn_m;
    assign b_m   = b ^ sgn_m;

    assign adv      = !vld[NSTG-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [CHUNK-1:0] ca, cb;
        logic             pv, pd, pg;
        logic             vld_q, dec_q, gtr_q;

        if (k == 0) begin : g_in
            assign ca = a_m[WIDTH-1 -: CHUNK];
            assign cb = b_m[WIDTH-1 -: CHUNK];
            assign pv = in_valid;
            assign pd = 1'b0;
            assign pg = 1'b0;
        end else begin : g_in
            assign ca = g_stg[k-1].g_rem.ra_q[WIDTH-k*CHUNK-1 -: CHUNK];
            assign cb = g_stg[k-1].g_rem.rb_q[WIDTH-k*CHUNK-1 -: CHUNK];
            assign pv = vld[k-1];
            assign pd = dec[k-1];
            assign pg = gtr[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dec_q <= 1'b0;
                gtr_q <= 1'b0;
            end else if (adv) begin
                vld_q <= pv;
                dec_q <= pd || (ca != cb);
                gtr_q <= pd ? pg : (ca > cb);
            end
        end

        assign vld[k] = vld_q;
        assign dec[k] = dec_q;
        assign gtr[k] = gtr_q;

        // Only the still-unresolved low slices travel down the pipe
        if (k < NSTG - 1) begin : g_rem
            logic [WIDTH-(k+1)*CHUNK-1:0] ra_q, rb_q, ra_d, rb_d;

            if (k == 0) begin : g_src
                assign ra_d = a_m[WIDTH-CHUNK-1:0];
                assign rb_d = b_m[WIDTH-CHUNK-1:0];
            end else begin : g_src
                assign ra_d = g_stg[k-1].g_rem.ra_q[WIDTH-(k+1)*CHUNK-1:0];
                assign rb_d = g_stg[k-1].g_rem.rb_q[WIDTH-(k+1)*CHUNK-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end
    end

    assign out_valid = vld[NSTG-1];
    assign eq        = vld[NSTG-1] && !dec[NSTG-1];
    assign gt        = vld[NSTG-1] && dec[NSTG-1] && gtr[NSTG-1];
    assign lt        = vld[NSTG-1] && dec[NSTG-1] && !gtr[NSTG-1];

`ifdef CMP_COUNTERS_EN
    logic             hs;
    logic [CNT_W-1:0] eq_cnt_q, gt_cnt_q, lt_cnt_q;
    logic [CNT_W-1:0] eq_cnt_d, gt_cnt_d, lt_cnt_d;

    assign hs = out_valid && out_ready;

    always_comb begin
        eq_cnt_d = eq_cnt_q;
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        if (cnt_clr) begin
            eq_cnt_d = '0;
            gt_cnt_d = '0;
            lt_cnt_d = '0;
        end else if (hs) begin
            if (eq && !(&eq_cnt_q)) eq_cnt_d = eq_cnt_q + CNT_W'(1);
            if (gt && !(&gt_cnt_q)) gt_cnt_d = gt_cnt_q + CNT_W'(1);
            if (lt && !(&lt_cnt_q)) lt_cnt_d = lt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt_q <= '0;
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            eq_cnt_q <= eq_cnt_d;
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
        end
    end

    assign eq_cnt = eq_cnt_q;
    assign gt_cnt = gt_cnt_q;
    assign lt_cnt = lt_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: 16/4, 4/4 and 32/1 instances checked against a
// signed/unsigned reference through per-instance result queues.
module tb_cmp_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        iv16, ir16, s16, ov16, or16, eq16, gt16, lt16;
    logic [15:0] a16, b16;
    logic        iv4, ir4, s4, ov4, or4, eq4, gt4, lt4;
    logic [3:0]  a4, b4;
    logic        iv32, ir32, s32, ov32, or32, eq32, gt32, lt32;
    logic [31:0] a32, b32;

`ifdef CMP_COUNTERS_EN
    logic        cc16, cc4, cc32;
    logic [15:0] ec16, gc16, lc16, ec32, gc32, lc32;
    logic [1:0]  ec4, gc4, lc4;
`endif

    logic [2:0] q16[$];
    logic [2:0] q4[$];
    logic [2:0] q32[$];
    int n16 = 0;
    int n4  = 0;
    int n32 = 0;

    cmp_pipe #(.WIDTH(16), .CHUNK(4)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .is_signed(s16), .out_valid(ov16),
        .out_ready(or16), .eq(eq16), .gt(gt16), .lt(lt16)
`ifdef CMP_COUNTERS_EN
        , .cnt_clr(cc16), .eq_cnt(ec16), .gt_cnt(gc16), .lt_cnt(lc16)
`endif
    );

    cmp_pipe #(.WIDTH(4), .CHUNK(4), .CNT_W(2)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .is_signed(s4), .out_valid(ov4),
        .out_ready(or4), .eq(eq4), .gt(gt4), .lt(lt4)
`ifdef CMP_COUNTERS_EN
        , .cnt_clr(cc4), .eq_cnt(ec4), .gt_cnt(gc4), .lt_cnt(lc4)
`endif
    );

    cmp_pipe #(.WIDTH(32), .CHUNK(1)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .is_signed(s32), .out_valid(ov32),
        .out_ready(or32), .eq(eq32), .gt(gt32), .lt(lt32)
`ifdef CMP_COUNTERS_EN
        , .cnt_clr(cc32), .eq_cnt(ec32), .gt_cnt(gc32), .lt_cnt(lc32)
`endif
    );

    // Reference: {lt, gt, eq} from sign-extended integer comparison
    function automatic logic [2:0] ref_cmp(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input bit s, input int w);
        longint xv, yv;
        xv = longint'({32'h0, x});
        yv = longint'({32'h0, y});
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        return {xv < yv, xv > yv, xv == yv};
    endfunction

    always @(negedge clk) begin : mon16
        logic [2:0] e;
        if (rst) q16.delete();
        else begin
            if (ov16 && or16) begin
                total++; n16++;
                if (q16.size() == 0) begin
                    bad++;
                    $display("FAIL out16 extra result {lt,gt,eq}=%b", {lt16, gt16, eq16});
                end else begin
                    e = q16.pop_front();
                    if ({lt16, gt16, eq16} !== e) begin
                        bad++;
                        $display("FAIL out16 result got=%b want=%b", {lt16, gt16, eq16}, e);
                    end
                end
            end else if (!ov16) begin
                total++;
                if ({lt16, gt16, eq16} !== 3'b000) begin
                    bad++;
                    $display("FAIL idle16 got=%b want=000", {lt16, gt16, eq16});
                end
            end
            if (iv16 && ir16) q16.push_back(ref_cmp(32'(a16), 32'(b16), s16, 16));
        end
    end

    always @(negedge clk) begin : mon4
        logic [2:0] e;
        if (rst) q4.delete();
        else begin
            if (ov4 && or4) begin
                total++; n4++;
                if (q4.size() == 0) begin
                    bad++;
                    $display("FAIL out4 extra result {lt,gt,eq}=%b", {lt4, gt4, eq4});
                end else begin
                    e = q4.pop_front();
                    if ({lt4, gt4, eq4} !== e) begin
                        bad++;
                        $display("FAIL out4 result got=%b want=%b", {lt4, gt4, eq4}, e);
                    end
                end
            end
            if (iv4 && ir4) q4.push_back(ref_cmp(32'(a4), 32'(b4), s4, 4));
        end
    end

    always @(negedge clk) begin : mon32
        logic [2:0] e;
        if (rst) q32.delete();
        else begin
            if (ov32 && or32) begin
                total++; n32++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL out32 extra result {lt,gt,eq}=%b", {lt32, gt32, eq32});
                end else begin
                    e = q32.pop_front();
                    if ({lt32, gt32, eq32} !== e) begin
                        bad++;
                        $display("FAIL out32 result got=%b want=%b", {lt32, gt32, eq32}, e);
                    end
                end
            end
            if (iv32 && ir32) q32.push_back(ref_cmp(a32, b32, s32, 32));
        end
    end

    function automatic logic ir_of(input int d);
        case (d)
            4:       return ir4;
            32:      return ir32;
            default: return ir16;
        endcase
    endfunction

    function automatic logic ov_of(input int d);
        case (d)
            4:       return ov4;
            32:      return ov32;
            default: return ov16;
        endcase
    endfunction

    function automatic int qsz(input int d);
        case (d)
            4:       return q4.size();
            32:      return q32.size();
            default: return q16.size();
        endcase
    endfunction

    // Present one pair and hold it until accepted; returns just after the accepting edge
    task automatic send(input int d, input logic [31:0] x, input logic [31:0] y, input bit s);
        int n;
        bit ok;
        n = 0;
        case (d)
            4:       begin a4 = x[3:0]; b4 = y[3:0]; s4 = s; iv4 = 1'b1; end
            32:      begin a32 = x; b32 = y; s32 = s; iv32 = 1'b1; end
            default: begin a16 = x[15:0]; b16 = y[15:0]; s16 = s; iv16 = 1'b1; end
        endcase
        do begin
            @(negedge clk);
            ok = ir_of(d);
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send%0d in_ready low for %0d cycles want accept", d, n);
        end
    endtask

    // Counts accepting edge plus further edges until out_valid is seen
    task automatic measure_lat(input int d, output int n);
        n = 1;
        while (!ov_of(d) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsz(d) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (qsz(d) != 0) begin
            bad++;
            $display("FAIL drain%0d pending=%0d want 0", d, qsz(d));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv16 = 0; iv4 = 0; iv32 = 0;
        s16 = 0; s4 = 0; s32 = 0;
        a16 = 0; b16 = 0; a4 = 0; b4 = 0; a32 = 0; b32 = 0;
        or16 = 1; or4 = 1; or32 = 1;
`ifdef CMP_COUNTERS_EN
        cc16 = 0; cc4 = 0; cc32 = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ov16, lt16, gt16, eq16} !== 4'b0000) begin
            bad++;
            $display("FAIL reset16 ov,lt,gt,eq=%b want 0000", {ov16, lt16, gt16, eq16});
        end
        total++;
        if ({ov4, ov32, ir16, ir4, ir32} !== 5'b00111) begin
            bad++;
            $display("FAIL reset_misc ov4,ov32,ir16,ir4,ir32=%b want 00111",
                     {ov4, ov32, ir16, ir4, ir32});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned;
        logic [31:0] ta[3] = '{32'h1234, 32'h8000, 32'h0000};
        logic [31:0] tb[3] = '{32'h1234, 32'h7FFF, 32'h0001};
        logic [2:0]  te[3] = '{3'b001, 3'b010, 3'b100};
        int n;
        for (int i = 0; i < 3; i++) begin
            send(16, ta[i], tb[i], 1'b0);
            measure_lat(16, n);
            total++;
            if (n != 4) begin
                bad++;
                $display("FAIL unsigned_lat%0d got=%0d want=4", i, n);
            end
            total++;
            if ({lt16, gt16, eq16} !== te[i]) begin
                bad++;
                $display("FAIL unsigned%0d got=%b want=%b", i, {lt16, gt16, eq16}, te[i]);
            end
            drain(16);
        end
    endtask

    task automatic test_signed;
        logic [31:0] ta[3] = '{32'h8000, 32'h8000, 32'hFFFF};
        logic [31:0] tb[3] = '{32'h0001, 32'h0001, 32'hFFFE};
        bit          ts[3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  te[3] = '{3'b100, 3'b010, 3'b010};
        int n;
        for (int i = 0; i < 3; i++) begin
            send(16, ta[i], tb[i], ts[i]);
            measure_lat(16, n);
            total++;
            if ({lt16, gt16, eq16} !== te[i]) begin
                bad++;
                $display("FAIL signed%0d got=%b want=%b", i, {lt16, gt16, eq16}, te[i]);
            end
            drain(16);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y;
        int n0;
        n0 = n16;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    x = $urandom;
                    y = (i % 3 == 0) ? x : $urandom;
                    send(16, x, y, bit'(i & 1));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                or16 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total++;
                    if (ov16 !== 1'b1 || ir16 !== 1'b0) begin
                        bad++;
                        $display("FAIL stall ov=%b ir=%b want ov=1 ir=0", ov16, ir16);
                    end
                    @(posedge clk);
                    #1;
                end
                or16 = 1'b1;
            end
        join
        drain(16);
        total++;
        if (n16 - n0 != 8) begin
            bad++;
            $display("FAIL stream_count got=%0d want=8", n16 - n0);
        end
    endtask

    task automatic test_reset_midflight;
        int n, n0;
        send(16, 32'h0010, 32'h0020, 1'b0);
        send(16, 32'h0030, 32'h0030, 1'b0);
        send(16, 32'hF000, 32'h0001, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (ov16 !== 1'b1) begin
            bad++;
            $display("FAIL midflight_pre ov=%b want=1", ov16);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ov16, lt16, gt16, eq16} !== 4'b0000) begin
            bad++;
            $display("FAIL midflight_rst ov,lt,gt,eq=%b want 0000", {ov16, lt16, gt16, eq16});
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n0 = n16;
        send(16, 32'h00FF, 32'h00FE, 1'b0);
        measure_lat(16, n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL midflight_lat got=%0d want=4", n);
        end
        drain(16);
        total++;
        if (n16 - n0 != 1) begin
            bad++;
            $display("FAIL midflight_count got=%0d want=1", n16 - n0);
        end
    endtask

    task automatic test_corners;
        logic [31:0] x, y;
        int n;
        send(4, 32'h8, 32'h7, 1'b1);
        measure_lat(4, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL w4_lat got=%0d want=1", n);
        end
        total++;
        if ({lt4, gt4, eq4} !== 3'b100) begin
            bad++;
            $display("FAIL w4_signed got=%b want=100", {lt4, gt4, eq4});
        end
        drain(4);
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = (i % 4 == 0) ? x : $urandom;
            send(4, x, y, bit'($urandom_range(0, 1)));
        end
        drain(4);

        send(32, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        measure_lat(32, n);
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL w32_lat got=%0d want=32", n);
        end
        total++;
        if ({lt32, gt32, eq32} !== 3'b010) begin
            bad++;
            $display("FAIL w32_unsigned got=%b want=010", {lt32, gt32, eq32});
        end
        drain(32);
        send(32, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = (i % 4 == 0) ? x : (x ^ (32'h1 << $urandom_range(0, 31)));
            send(32, x, y, bit'($urandom_range(0, 1)));
        end
        drain(32);
    endtask

`ifdef CMP_COUNTERS_EN
    task automatic test_counters;
        cc4 = 1'b1;
        @(posedge clk);
        #1;
        cc4 = 1'b0;
        total++;
        if ({ec4, gc4, lc4} !== 6'b0) begin
            bad++;
            $display("FAIL cnt_clr got eq,gt,lt=%b want 0", {ec4, gc4, lc4});
        end
        for (int i = 0; i < 5; i++) send(4, 32'h5, 32'h3, 1'b0);
        drain(4);
        total++;
        if (gc4 !== 2'd3 || ec4 !== 2'd0 || lc4 !== 2'd0) begin
            bad++;
            $display("FAIL cnt_sat got eq=%0d gt=%0d lt=%0d want 0 3 0", ec4, gc4, lc4);
        end
        send(4, 32'h6, 32'h6, 1'b0);
        drain(4);
        total++;
        if (ec4 !== 2'd1) begin
            bad++;
            $display("FAIL cnt_eq got=%0d want=1", ec4);
        end
        send(4, 32'h9, 32'h9, 1'b0);
        cc4 = 1'b1;
        @(posedge clk);
        #1;
        cc4 = 1'b0;
        total++;
        if (ec4 !== 2'd0 || gc4 !== 2'd0) begin
            bad++;
            $display("FAIL cnt_clr_prio got eq=%0d gt=%0d want 0 0", ec4, gc4);
        end
        drain(4);
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_midflight();
        test_corners();
`ifdef CMP_COUNTERS_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
